// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: valid/ready byte stream from the UART receiver FIFO to its consumer.
//   rdata  : FIFO head byte (meaningful only while rvalid)
//   rvalid : FIFO non-empty
//   rready : consumer takes rdata on a cycle with rvalid && rready
//   master : receiver side, slave : consumer side
interface uart_rx_fifo_if;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
    modport master (output rdata, rvalid, input rready);
    modport slave  (input rdata, rvalid, output rready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a first-word-fall-through byte FIFO.
//   clk     : system clock
//   rstn    : asynchronous active-low reset
//   rxd     : serial input, idle high, LSB first
//   rx      : uart_rx_fifo_if.master valid/ready stream of received bytes
//   ferr    : one-cycle pulse, stop bit sampled low (byte discarded)
//   overrun : one-cycle pulse, completed byte dropped because the FIFO was full
//   perr    : one-cycle pulse, even-parity mismatch (only with UART_RX_PARITY_EN)
//   count   : bytes currently held
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state and the perr port.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          rxd,
    uart_rx_fifo_if.master                rx,
    output logic                          ferr,
    output logic                          overrun,
`ifdef UART_RX_PARITY_EN
    output logic                          perr,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t state, state_d;
    logic rx_meta, rxs;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0] bit_idx, bit_d;
    logic [7:0] sh, sh_d;
    logic tick, push, ferr_d, par_ok;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic pop_ok, push_ok;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d, perr_d;
    assign par_ok = par_q == ^sh;
`else
    assign par_ok = 1'b1;
`endif

    assign tick = cnt == '0;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) {rxs, rx_meta} <= 2'b11;
        else {rxs, rx_meta} <= {rx_meta, rxd};

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr    <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            sh      <= sh_d;
            ferr    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr    <= perr_d;
`endif
        end

    always_comb begin
        state_d = state;
        cnt_d   = cnt - CW'(1);
        bit_d   = bit_idx;
        sh_d    = sh;
        push    = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state)
            IDLE: begin
                bit_d   = '0;
                cnt_d   = rxs ? '0 : HALF;
                state_d = rxs ? IDLE : START;
            end
            START: if (tick) begin
                cnt_d   = FULL_BIT;
                state_d = rxs ? IDLE : DATA;
            end
            DATA: if (tick) begin
                cnt_d = FULL_BIT;
                sh_d  = {rxs, sh[7:1]};
                bit_d = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (bit_idx == 3'd7) state_d = PARITY;
`else
                if (bit_idx == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                cnt_d   = FULL_BIT;
                par_d   = rxs;
                state_d = STOP;
            end
`endif
            STOP: if (tick) begin
                push    = rxs && par_ok;
                ferr_d  = !rxs;
`ifdef UART_RX_PARITY_EN
                perr_d  = rxs && !par_ok;
`endif
                state_d = rxs ? IDLE : BREAK;
            end
            BREAK: begin
                cnt_d   = '0;
                state_d = rxs ? IDLE : BREAK;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx.rvalid = count != '0;
    assign pop_ok    = rx.rvalid && rx.rready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok   = push && (count != DEPTH || pop_ok);

    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= sh;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx.rdata <= '0;
            overrun  <= 1'b0;
        end else begin
            overrun <= push && !push_ok;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
            // The head register reloads only when the head slot changes: a push into an
            // empty (or emptying) FIFO, or a pop that exposes the next stored byte.
            if (push_ok && (count == '0 || (count == (AW+1)'(1) && pop_ok))) rx.rdata <= sh;
            else if (pop_ok && count > (AW+1)'(1)) rx.rdata <= mem[rd_ptr + AW'(1)];
        end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo (CLKS_PER_BIT=8, FIFO_DEPTH=4).
module tb_uart_rx_fifo;
    localparam int C = 8;
    localparam int D = 4;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_OFS = 2 + C / 2 + 10 * C;
`else
    localparam int STOP_OFS = 2 + C / 2 + 9 * C;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rxd = 1'b1;
    logic ferr, overrun;
    logic [2:0] count;
`ifdef UART_RX_PARITY_EN
    logic perr;
`endif
    uart_rx_fifo_if bus ();

    uart_rx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk),
        .rstn(rstn),
        .rxd(rxd),
        .rx(bus),
        .ferr(ferr),
        .overrun(overrun),
`ifdef UART_RX_PARITY_EN
        .perr(perr),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int n_ferr = 0, n_ovr = 0, n_perr = 0, n_valid = 0, max_cnt = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: samples mid-cycle after the negedge drivers have settled.
    initial forever begin : monitor
        logic [7:0] e;
        @(negedge clk);
        #2;
        if (rstn) begin
            n_ferr  += int'(ferr);
            n_ovr   += int'(overrun);
`ifdef UART_RX_PARITY_EN
            n_perr  += int'(perr);
`endif
            n_valid += int'(bus.rvalid);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (bus.rvalid && bus.rready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL pop_unexpected: got 0x%0h expected no byte", bus.rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rdata !== e) begin
                        n_bad++;
                        $display("FAIL pop_data: got 0x%0h expected 0x%0h", bus.rdata, e);
                    end
                end
            end
        end
    end

    task automatic clear_stats();
        n_ferr = 0; n_ovr = 0; n_perr = 0; n_valid = 0; max_cnt = 0;
    endtask

    task automatic bit_out(input logic v);
        rxd = v;
        repeat (C) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_out(^b ^ par_flip);
`endif
        bit_out(stop_bit);
        rxd = 1'b1;
    endtask

    initial begin
        bus.rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", int'(bus.rdata), 0);
        chk("rst_rvalid", int'(bus.rvalid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_ferr", int'(ferr), 0);
        chk("rst_overrun", int'(overrun), 0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // single byte, consumer always ready
        clear_stats();
        bus.rready = 1'b1;
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("a5_valid_cycles", n_valid, 1);
        chk("a5_max_count", max_cnt, 1);
        chk("a5_count_after", int'(count), 0);
        chk("a5_ferr", n_ferr, 0);

        // two-clock low glitch on idle line
        clear_stats();
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_ferr", n_ferr, 0);
        chk("glitch_valid", n_valid, 0);

        // bad stop bit, then line held low, then a clean frame
        clear_stats();
        send(8'h3C, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        chk("break_ferr", n_ferr, 1);
        chk("break_count", int'(count), 0);
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("after_break_count", int'(count), 0);
        chk("after_break_valid", n_valid, 1);

        // fill and overrun with consumer stalled
        clear_stats();
        bus.rready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send(8'(i), 1'b1, 1'b0);
        end
        repeat (5) @(negedge clk);
        chk("full_count", int'(count), 4);
        chk("full_overrun", n_ovr, 1);
        chk("full_head", int'(bus.rdata), 1);

        // push on a full FIFO in the same cycle as a pop
        clear_stats();
        exp_q.push_back(8'h77);
        fork
            send(8'h77, 1'b1, 1'b0);
            begin
                repeat (STOP_OFS) @(negedge clk);
                bus.rready = 1'b1;
                @(negedge clk);
                bus.rready = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        chk("simul_overrun", n_ovr, 0);
        chk("simul_count", int'(count), 4);
        bus.rready = 1'b1;
        repeat (10) @(negedge clk);
        chk("drain_count", int'(count), 0);

`ifdef UART_RX_PARITY_EN
        clear_stats();
        send(8'h03, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("par_bad_perr", n_perr, 1);
        chk("par_bad_valid", n_valid, 0);
        clear_stats();
        exp_q.push_back(8'h03);
        send(8'h03, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("par_ok_perr", n_perr, 0);
        chk("par_ok_valid", n_valid, 1);
`endif

        chk("sb_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
